// File: rtl/song_pkg.sv
// Song-memory word format shared by the recorder and the song reader,
// plus the recorder state encoding and word-building helpers.
package song_pkg;

  localparam int SONG_LEN = 128;
  localparam int ADDR_W   = 7;
  localparam int DUR_MAX  = 63;

  localparam int ADV_BIT = 15;
  localparam int NOTE_HI = 14;
  localparam int NOTE_LO = 9;
  localparam int DUR_HI  = 8;
  localparam int DUR_LO  = 3;

  localparam logic [15:0]       REST_WORD = 16'h8000;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REC,
    S_WR_ADV,
    S_WR_NOTE,
    S_FLUSH,
    S_PAD,
    S_DONE
  } rec_state_e;

  function automatic logic [15:0] note_word(input logic [5:0] note, input logic [5:0] dur);
    logic [15:0] w;
    w = '0;
    w[NOTE_HI:NOTE_LO] = note;
    w[DUR_HI:DUR_LO]   = dur;
    return w;
  endfunction

  function automatic logic [15:0] adv_word(input logic [5:0] beats);
    logic [15:0] w;
    w = '0;
    w[ADV_BIT]       = 1'b1;
    w[DUR_HI:DUR_LO] = beats;
    return w;
  endfunction

  function automatic logic [5:0] sat_inc(input logic [5:0] val, input logic inc);
    return (inc && (val != 6'(DUR_MAX))) ? val + 6'd1 : val;
  endfunction

endpackage

// File: rtl/song_recorder_beat_accumulator.sv
// Saturating 6-bit beat counter with clear; a beat landing on the clear
// cycle is kept so the next advance word never loses it.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk_i) begin
    if (reset_i) q_o <= '0;
    else         q_o <= d_i;
  end
endmodule

module beat_accumulator
  import song_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [5:0] elapsed_o,
  output logic       sat_o
);
  logic [5:0] elapsed_d;
  logic [5:0] elapsed_q;

  assign elapsed_d = clr_i ? {5'd0, inc_i} : sat_inc(elapsed_q, inc_i);

  dffr #(.W(6)) u_elapsed (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (elapsed_d),
    .q_o    (elapsed_q)
  );

  assign elapsed_o = elapsed_q;
  assign sat_o     = (elapsed_q == 6'(DUR_MAX));
endmodule

// File: rtl/song_recorder.sv
// Encodes live notes plus beat gaps into song RAM words; all outputs registered.
// state     | meaning
// IDLE      | waiting for record
// REC       | accepting notes, counting beats
// WR_ADV    | advance word on the bus, note word queued
// WR_NOTE   | note word on the bus
// FLUSH     | trailing advance (if any) on the bus
// PAD       | filling the rest of the song with rest words
// DONE      | slot 127 written, back to IDLE next cycle
module song_recorder
  import song_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        record_i,
  input  logic        stop_i,
  input  logic [1:0]  song_i,
  input  logic        beat_i,
  input  logic        note_valid_i,
  input  logic [5:0]  note_i,
  input  logic [5:0]  dur_i,
  output logic        note_ready_o,
  output logic        wr_en_o,
  output logic [8:0]  wr_addr_o,
  output logic [15:0] wr_data_o,
  output logic        busy_o,
  output logic        rec_done_o,
  output logic        overflow_o
);

  rec_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        song_q, song_d;
  logic [5:0]        note_q, note_d, dur_q, dur_d;
  logic              stop_pend_q, stop_pend_d;
  logic              wr_en_q, wr_en_d;
  logic [8:0]        wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              note_ready_q, busy_q, rec_done_q, rec_done_d, overflow_q, overflow_d;

  logic       acc_clr, acc_inc, sat, accept, full;
  logic [5:0] elapsed, elapsed_eff;

  beat_accumulator u_acc (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (acc_clr),
    .inc_i    (acc_inc),
    .elapsed_o(elapsed),
    .sat_o    (sat)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    song_d      = song_q;
    note_d      = note_q;
    dur_d       = dur_q;
    stop_pend_d = stop_pend_q;
    overflow_d  = overflow_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    wr_addr_d   = {song_q, addr_q};
    rec_done_d  = 1'b0;
    acc_clr     = 1'b0;
    acc_inc     = beat_i && (state_q inside {S_REC, S_WR_ADV, S_WR_NOTE});
    accept      = note_valid_i && note_ready_q;
    elapsed_eff = sat_inc(elapsed, acc_inc);
    full        = (addr_q == ADDR_LAST);

    case (state_q)
      S_IDLE: if (record_i) begin
        song_d      = song_i;
        addr_d      = '0;
        overflow_d  = 1'b0;
        stop_pend_d = 1'b0;
        acc_clr     = 1'b1;
        state_d     = S_REC;
      end
      S_REC: begin
        if (accept) begin
          note_d      = note_i;
          dur_d       = dur_i;
          stop_pend_d = stop_i;
          wr_en_d     = 1'b1;
          if (elapsed_eff != 6'd0) begin
            wr_data_d = adv_word(elapsed_eff);
            state_d   = S_WR_ADV;
          end else begin
            wr_data_d = note_word(note_i, dur_i);
            state_d   = S_WR_NOTE;
          end
        end else if (stop_i) begin
          state_d   = S_FLUSH;
          wr_en_d   = (elapsed_eff != 6'd0);
          wr_data_d = adv_word(elapsed_eff);
        end else if (sat) begin
          wr_en_d   = 1'b1;
          wr_data_d = adv_word(6'(DUR_MAX));
          acc_clr   = 1'b1;
        end
      end
      S_WR_ADV: begin
        stop_pend_d = stop_pend_q | stop_i;
        acc_clr     = 1'b1;
        wr_en_d     = 1'b1;
        wr_data_d   = note_word(note_q, dur_q);
        state_d     = S_WR_NOTE;
      end
      S_WR_NOTE: begin
        state_d = S_REC;
        if (stop_pend_q || stop_i) begin
          stop_pend_d = 1'b0;
          state_d     = S_FLUSH;
          wr_en_d     = (elapsed_eff != 6'd0);
          wr_data_d   = adv_word(elapsed_eff);
        end
      end
      S_FLUSH, S_PAD: begin
        wr_en_d   = 1'b1;
        wr_data_d = REST_WORD;
        state_d   = S_PAD;
        if (full) begin
          rec_done_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Slot 127 is reserved for the closing rest; any recording write landing there ends the song.
    if (wr_en_d && full && (state_q inside {S_REC, S_WR_ADV, S_WR_NOTE})) begin
      wr_data_d  = REST_WORD;
      overflow_d = 1'b1;
      rec_done_d = 1'b1;
      state_d    = S_DONE;
    end
    if (wr_en_d) addr_d = addr_q + 7'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      song_q       <= '0;
      note_q       <= '0;
      dur_q        <= '0;
      stop_pend_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      note_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      rec_done_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      song_q       <= song_d;
      note_q       <= note_d;
      dur_q        <= dur_d;
      stop_pend_q  <= stop_pend_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      note_ready_q <= (state_d == S_REC);
      busy_q       <= (state_d != S_IDLE);
      rec_done_q   <= rec_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign note_ready_o = note_ready_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;
  assign rec_done_o   = rec_done_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_song_recorder.sv
// Bench for song_recorder: expected RAM write stream built from a word-level
// model of the recording rules, compared against every observed write.
module tb_song_recorder;
  logic        clk_i = 1'b0;
  logic        reset_i, record_i, stop_i, beat_i, note_valid_i;
  logic [1:0]  song_i;
  logic [5:0]  note_i, dur_i;
  logic        note_ready_o, wr_en_o, busy_o, rec_done_o, overflow_o;
  logic [8:0]  wr_addr_o;
  logic [15:0] wr_data_o;

  int n_chk = 0, n_fail = 0;
  logic [24:0] obs_q[$], exp_q[$];
  int          done_cnt;
  logic [8:0]  done_addr;
  int          m_addr, m_el;
  logic [1:0]  m_song;
  bit          m_done, m_over;

  song_recorder dut (
    .clk_i(clk_i), .reset_i(reset_i), .record_i(record_i), .stop_i(stop_i),
    .song_i(song_i), .beat_i(beat_i), .note_valid_i(note_valid_i), .note_i(note_i),
    .dur_i(dur_i), .note_ready_o(note_ready_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .busy_o(busy_o), .rec_done_o(rec_done_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (wr_en_o) obs_q.push_back({wr_addr_o, wr_data_o});
    if (rec_done_o) begin done_cnt++; done_addr = wr_addr_o; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] adv(input int b);
    return 16'h8000 | 16'(b * 8);
  endfunction
  function automatic logic [15:0] nw(input int n, input int d);
    return 16'(n * 512 + d * 8);
  endfunction
  function automatic void m_emit(input logic [15:0] w);
    if (m_done) return;
    if (m_addr == 127) begin
      exp_q.push_back({m_song, 7'd127, 16'h8000});
      m_over = 1; m_done = 1;
    end else begin
      exp_q.push_back({m_song, 7'(m_addr), w});
      m_addr++;
    end
  endfunction
  function automatic void m_beat();
    if (m_done) return;
    if (m_el < 63) m_el++;
    if (m_el == 63) begin m_emit(adv(63)); m_el = 0; end
  endfunction
  function automatic void m_note(input int n, input int d);
    if (m_el > 0) begin m_emit(adv(m_el)); m_el = 0; end
    m_emit(nw(n, d));
  endfunction
  function automatic void m_stop();
    if (m_el > 0) begin m_emit(adv(m_el)); m_el = 0; end
    while (!m_done) begin
      exp_q.push_back({m_song, 7'(m_addr), 16'h8000});
      if (m_addr == 127) m_done = 1;
      m_addr++;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic start(input logic [1:0] s);
    obs_q.delete(); exp_q.delete(); done_cnt = 0; done_addr = '0;
    song_i = s; record_i = 1'b1; tick(); record_i = 1'b0;
    m_song = s; m_addr = 0; m_el = 0; m_done = 0; m_over = 0;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      beat_i = 1'b1; tick(); beat_i = 1'b0; m_beat(); tick();
    end
  endtask

  task automatic do_stop(input bit b);
    stop_i = 1'b1; beat_i = b; tick(); stop_i = 1'b0; beat_i = 1'b0;
    if (b) m_beat();
    m_stop();
  endtask

  task automatic send_note(input string tag, input int n, input int d, input bit b,
                           input bit stp, input bit rnd);
    int low;
    n_chk++;
    if (note_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before: got %b expected 1", tag, note_ready_o);
    end
    note_valid_i = 1'b1; note_i = 6'(n); dur_i = 6'(d); beat_i = b; stop_i = stp; tick();
    note_valid_i = 1'b0; beat_i = 1'b0; stop_i = 1'b0;
    if (b) m_beat();
    low = (m_el > 0) ? 2 : 1;
    m_note(n, d);
    if (stp) m_stop();
    else if (!m_done) begin
      for (int i = 0; i <= low; i++) begin
        n_chk++;
        if (note_ready_o !== (i == low)) begin
          n_fail++; $display("FAIL %s ready_gap[%0d]: got %b expected %b", tag, i, note_ready_o, i == low);
        end
        if (i < low) begin
          beat_i = rnd && ($urandom_range(0, 3) == 0);
          tick();
          if (beat_i) m_beat();
          beat_i = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy_o !== 1'b0 && k < 400) begin tick(); k++; end
    n_chk++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL %s idle_timeout: busy=%b expected 0", tag, busy_o); end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] got[7];
    string nm[7] = '{"wr_en", "wr_addr", "wr_data", "note_ready", "busy", "rec_done", "overflow"};
    reset_i = 1'b1; record_i = 0; stop_i = 0; beat_i = 0; note_valid_i = 0;
    song_i = 0; note_i = 0; dur_i = 0;
    repeat (3) tick();
    reset_i = 1'b0; tick();
    got = '{16'(wr_en_o), 16'(wr_addr_o), wr_data_o, 16'(note_ready_o), 16'(busy_o),
            16'(rec_done_o), 16'(overflow_o)};
    foreach (got[i]) begin
      n_chk++;
      if (got[i] !== 16'h0) begin n_fail++; $display("FAIL reset_%s: got %h expected 0", nm[i], got[i]); end
    end
  endtask

  task automatic test_basic();
    start(2'd2);
    beats(4);
    send_note("basic", 20, 8, 0, 0, 0);
    n_chk++;
    if (obs_q.size() < 2 || obs_q[0] !== {9'h100, 16'h8020} || obs_q[1] !== {9'h101, 16'h2840}) begin
      n_fail++; $display("FAIL basic_first_words: got %p expected 100:8020 101:2840", obs_q);
    end
    do_stop(0);
    wait_idle("basic");
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_chk++;
    if (done_cnt != 1 || done_addr !== {m_song, 7'd127}) begin
      n_fail++; $display("FAIL basic_rec_done: got %0d pulses at %h expected 1 at %h", done_cnt, done_addr, {m_song, 7'd127});
    end
  endtask

  task automatic test_back_to_back();
    start(2'd1);
    beats(2);
    send_note("b2b_a", 33, 4, 0, 0, 0);
    send_note("b2b_b", 37, 4, 0, 0, 0);
    n_chk++;
    if (obs_q.size() != 3 || obs_q[2] !== {9'h082, 16'(37 * 512 + 4 * 8)}) begin
      n_fail++; $display("FAIL b2b_chord: got %0d writes last %h expected 3 writes last 082:4a20", obs_q.size(), obs_q[obs_q.size()-1]);
    end
    do_stop(0);
    wait_idle("b2b");
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_saturation();
    start(2'd0);
    beats(63);
    tick();
    n_chk++;
    if (obs_q.size() != 1 || obs_q[0] !== {9'h000, 16'h81F8}) begin
      n_fail++; $display("FAIL sat_word: got %0d writes first %h expected 1 write 000:81f8", obs_q.size(), obs_q[0]);
    end
    beats(1);
    do_stop(0);
    wait_idle("sat");
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL sat_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sat_word[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_chk++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL sat_rec_done: got %0d pulses expected 1", done_cnt); end
  endtask

  task automatic test_full();
    start(2'd3);
    for (int k = 0; k < 128; k++) send_note("full", k % 64, (k * 7) % 64, 0, 0, 0);
    wait_idle("full");
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_word[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_chk++;
    if (overflow_o !== m_over) begin n_fail++; $display("FAIL full_overflow: got %b expected %b", overflow_o, m_over); end
    n_chk++;
    if (done_cnt != 1 || done_addr !== 9'h1FF) begin
      n_fail++; $display("FAIL full_rec_done: got %0d pulses at %h expected 1 at 1ff", done_cnt, done_addr);
    end
  endtask

  task automatic test_stop_with_note();
    start(2'd0);
    n_chk++;
    if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL swn_overflow_clear: got %b expected 0", overflow_o); end
    beats(3);
    send_note("swn", 9, 5, 0, 1, 0);
    wait_idle("swn");
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL swn_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL swn_word[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      start(2'($urandom_range(0, 3)));
      for (int k = 0; k < 15; k++) begin
        beats($urandom_range(0, 3));
        send_note("rand", $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 3) == 0, 0, 1);
      end
      do_stop($urandom_range(0, 1));
      wait_idle("rand");
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", r, obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_word[%0d]: got %h expected %h", r, i, obs_q[i], exp_q[i]); end
      end
      n_chk++;
      if (overflow_o !== 1'b0 || done_cnt != 1) begin
        n_fail++; $display("FAIL rand%0d_end: got overflow=%b pulses=%0d expected 0 and 1", r, overflow_o, done_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    start(2'd1);
    do_stop(0);
    while (!(wr_en_o === 1'b1 && wr_addr_o[6:0] == 7'd50) && k < 200) begin tick(); k++; end
    n_chk++;
    if (k >= 200) begin n_fail++; $display("FAIL rmid_reach50: got timeout expected write at addr 50"); end
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    n_chk++;
    if (wr_en_o !== 1'b0 || busy_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL rmid_outputs: got wr_en=%b busy=%b overflow=%b expected 0 0 0", wr_en_o, busy_o, overflow_o);
    end
    repeat (5) tick();
    foreach (obs_q[i]) begin
      n_chk++;
      if (obs_q[i][22:16] > 7'd50) begin n_fail++; $display("FAIL rmid_no_write: got write %h expected none past addr 50", obs_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_full();
    test_stop_with_note();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/song_recorder.md
Name: song_recorder

Overview:
- Writer-side counterpart of the song reader. Captures live notes from the keyboard/UI front end and encodes them into song-memory words.
- Writes those words into the 4-song x 128-entry song RAM. The song reader plays the RAM back with the same word format and end-of-song rule: address wraps to 0.
- Sits between the note-entry front end and the song RAM write port. It is timed by the same beat strobe the player uses.

Parameters:
- SONG_LEN, 128, entries per song; address width is log2(SONG_LEN)=7.
- DUR_MAX, 63, maximum duration/elapsed value that fits in the 6-bit field.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- record  in  1  pulse; starts a recording in IDLE, ignored otherwise
- stop  in  1  pulse; ends the recording (flush + pad)
- song  in  2  target song slot, latched on record
- beat  in  1  one-cycle beat strobe (same as playback)
- note_valid  in  1  note entry request
- note  in  6  note number to record
- dur  in  6  note duration in beats
- note_ready  out  1  high only in REC; a note is accepted when note_valid&note_ready
- wr_en  out  1  song RAM write strobe
- wr_addr  out  9  {song_latched, addr[6:0]}
- wr_data  out  16  encoded word
- busy  out  1  high in every state except IDLE
- rec_done  out  1  one-cycle pulse when the last slot (addr 127) is written
- overflow  out  1  sticky; set when the song fills before stop; cleared on record/reset

Behaviour:
- Word format:
  - Note word: bit15=0, [14:9]=note, [8:3]=dur, [2:0]=0.
  - Advance word: bit15=1, [14:9]=0, [8:3]=beats, [2:0]=0.
  - Rest/pad word: 16'h8000.
- All outputs are registered.
- Reset values: state IDLE, addr 0, elapsed 0, wr_en 0, wr_addr 0, wr_data 0, note_ready 0, busy 0, rec_done 0, overflow 0.
- Reset mid-operation aborts immediately with no further writes. Partially written RAM is left as is.
- States: IDLE, REC, WR_ADV, WR_NOTE, FLUSH, PAD, DONE.
- IDLE:
  - On record: latch song, addr<=0, elapsed<=0, overflow<=0, go to REC.
- elapsed counter (6 bits):
  - Increments on beat in REC, WR_ADV and WR_NOTE, so beats are never lost.
  - Cleared in the cycle the advance word is written. If a beat coincides with that clear, the result is 1.
- REC, note accepted in cycle N:
  - Note and dur are latched.
  - If elapsed (including any beat at N) > 0: cycle N+1 writes an advance word {elapsed}, then cycle N+2 writes the note word.
  - If elapsed == 0 (chord): cycle N+1 writes the note word directly.
  - note_ready is low during WR_ADV/WR_NOTE and returns high the cycle after the note write.
- Saturation: if elapsed reaches 63 in REC with no pending note, write advance word 16'h81F8 next cycle and clear elapsed.
- addr increments by 1 after every write.
- Full rule: slot 127 is reserved for the rest word. When a write would target addr 127 from REC/WR_* states:
  - write 16'h8000 at 127,
  - set overflow,
  - pulse rec_done,
  - go to DONE.
  - Any pending note word is dropped.
- stop in REC:
  - Go to FLUSH. FLUSH writes advance {elapsed} if elapsed>0, else no write.
  - Then go to PAD. PAD writes 16'h8000 at every remaining addr up to and including 127, one per cycle.
  - After the write at addr 127: rec_done pulses, then DONE.
- stop arriving during WR_ADV/WR_NOTE is latched and taken once the note write completes.
- stop and note_valid in the same REC cycle: the note is accepted first, and stop is handled after its writes.
- DONE returns to IDLE the next cycle. record is ignored outside IDLE.
- Duration arithmetic: 6-bit, no wrap; elapsed saturates at 63.

Decomposition:
- Shared package song_pkg:
  - ADV_BIT=15, NOTE_HI/LO=14/9, DUR_HI/LO=8/3, REST_WORD=16'h8000, SONG_LEN=128, state encodings.
  - The song reader uses the same field constants.
- One natural sub-module: beat_accumulator. It provides the 6-bit saturating elapsed counter with clear and a sat flag, built on dffr.

Test Plan:
- Reset, then record (song=2); beat x4; note=20,dur=8 valid -> writes addr 0x100=16'h8020, 0x101=16'h2840; note_ready low for 2 cycles.
- Two notes accepted back-to-back with no intervening beat -> second note word written directly, with no advance word between the two.
- 63 beats with no notes -> single write 16'h81F8, elapsed restarts at 0; a 64th beat then stop -> flush 16'h8008, pad to addr 127, rec_done pulses once at the 127 write.
- Enter 126 chord notes with no beats (addr 0..125 filled); next accepted note -> addr 126 note word written; following note -> addr 127=16'h8000, overflow=1, rec_done pulse, pending note dropped.
- stop asserted in the same cycle as note_valid after 3 beats -> 16'h8018, note word, then pad words, correct order.
- reset asserted during PAD at addr 50 -> wr_en low next cycle, busy=0, overflow=0, no write at addr 51.
